reload_scheduler: RTL and testbench
===================================

Name: reload_scheduler

Overview:
- Upstream feeder for the 4-bit self-reloading counter. Drives the counter's load strobe and load value.
- Software or an upstream master pushes reload values through a valid/ready port into a small FIFO.
- The block watches the counter output. When it equals a terminal value, the block pops the next reload value and pulses load in the same cycle, so the counter sequence is ..., term, next_val, next_val+1, ...
- Supports continuous and one-shot modes, and flags underrun when the FIFO is empty at a reload point.

Parameters:
- WIDTH, 4: width of count, terminal and reload values.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- DEFAULT_VAL, 0: reset value of the last-value register.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable_i  input  1  arms the scheduler
- oneshot_i  input  1  1 = one reload per enable assertion; 0 = continuous
- term_i  input  WIDTH  terminal count that triggers a reload
- count_i  input  WIDTH  counter's current count
- in_valid_i  input  1  reload value offered
- in_val_i  input  WIDTH  reload value
- in_ready_o  output  1  FIFO can accept
- clr_underrun_i  input  1  clears sticky underrun flag
- load_o  output  1  counter load strobe (combinational)
- load_val_o  output  WIDTH  value to load (combinational)
- level_o  output  clog2(DEPTH)+1  FIFO occupancy
- underrun_o  output  1  sticky: reload occurred with FIFO empty

Behaviour:
- Reset values: clk, reset: reset synchronous, active-high; all state cleared on the clk edge with reset=1.
  - FSM = IDLE, FIFO empty, level_o=0, in_ready_o=1.
  - underrun_o=0, last_val=DEFAULT_VAL, load_o=0.
- FIFO:
  - in_ready_o = (level < DEPTH). The current-cycle pop is not counted, so a full FIFO is never written even if it pops that cycle.
  - Push when in_valid_i && in_ready_o.
  - Pop only on a reload event.
  - Simultaneous push and pop: level unchanged, order preserved.
  - No bypass: a push into an empty FIFO in a reload cycle is not visible to that reload.
  - Pointers wrap modulo DEPTH.
- match = (count_i == term_i), full WIDTH compare.
- FSM states:
  - IDLE: load_o=0. Goes to ARMED when enable_i=1.
  - ARMED: load_o = match.
    - Reload cycle, oneshot_i=1: go to DONE.
    - Reload cycle, oneshot_i=0: stay in ARMED.
    - enable_i=0 takes priority: go to IDLE with load_o=0 that cycle.
  - DONE: load_o=0. Goes to IDLE when enable_i=0.
  - FIFO pushes are accepted in all states.
- Reload event (load_o=1):
  - FIFO non-empty: load_val_o = FIFO head; head popped; last_val updated to that value on the edge.
  - FIFO empty: load_val_o = last_val; underrun_o set on the edge.
  - When load_o=0, load_val_o = head if non-empty, else last_val (no side effects).
- Latency: zero. The counter samples load_o on the same edge, so the count after term is the reload value.
- Re-trigger: if the loaded value equals term_i, the next cycle matches again and reloads again. This is legal; one pop per reload cycle.
- underrun_o: set has priority over clr_underrun_i in the same cycle; otherwise clears on clr_underrun_i.
- Reset mid-operation: FIFO contents discarded, FSM to IDLE, load_o=0 in the reset cycle.
- oneshot_i is sampled only in reload cycles; changing it mid-run affects only the next reload.

Optional Feature:
- Macro: RELOAD_SCHED_CNT_EN.
- Defined:
  - Adds output reload_cnt_o (8 bits), counting reload events.
  - Saturates at 255; cleared by reset and by clr_underrun_i.
  - An increment and a clear in the same cycle resolve to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Continuous basic:
  - Stimulus: push 9 then 3; term_i=12; oneshot_i=0; enable_i=1; counter model driven from load_o/load_val_o, starting at 0.
  - Required: load_o high when count=12; counter goes 12 -> 9; next match 12 -> 3; level_o 2 -> 1 -> 0.
- Underrun:
  - Stimulus: FIFO empty after the above; counter reaches 12 again.
  - Required: load_val_o=3 (last_val); underrun_o=1 from next cycle; clr_underrun_i pulse -> 0.
  - Same-cycle case: reload with empty FIFO while clr_underrun_i=1 -> underrun_o=1 afterwards.
- Full / backpressure:
  - Stimulus: DEPTH=4, enable_i=0; push 1,2,3,4; hold in_valid_i with 5.
  - Required: in_ready_o=0, level_o=4, 5 not accepted.
  - Then enable_i=1 and a reload: pops 1; 5 accepted the cycle after the pop; FIFO order 2,3,4,5.
- One-shot:
  - Stimulus: oneshot_i=1; push 7 and 8; term_i=15.
  - Required: single reload to 7; later count=15 gives no load_o; counter wraps 15 -> 0.
  - Then enable_i low for 1 cycle and high again: next 15 reloads 8.
- Simultaneous events:
  - Stimulus: FIFO empty; push 6 in the same cycle count==term.
  - Required: load_val_o=last_val and underrun_o set; 6 is loaded at the next match.
  - Separately, enable_i=0 in a match cycle -> load_o=0.
- Reset mid-run:
  - Stimulus: level_o=3, ARMED; reset=1 one cycle during a match.
  - Required: load_o=0 that cycle; level_o=0; underrun_o=0; load_val_o=DEFAULT_VAL; FSM in IDLE.
  - With RELOAD_SCHED_CNT_EN: reload_cnt_o=0, and 256 reloads saturate at 255.

Source files
------------

// File: rtl/reload_scheduler.sv
// Reload scheduler: feeds the self-reloading counter from a small FIFO whenever count hits the terminal value.
// Define RELOAD_SCHED_CNT_EN to add the saturating reload_cnt_o event counter.
module reload_scheduler #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      DEPTH       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic                       oneshot_i,
    input  logic [WIDTH-1:0]           term_i,
    input  logic [WIDTH-1:0]           count_i,
    input  logic                       in_valid_i,
    input  logic [WIDTH-1:0]           in_val_i,
    output logic                       in_ready_o,
    input  logic                       clr_underrun_i,
    output logic                       load_o,
    output logic [WIDTH-1:0]           load_val_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       underrun_o
`ifdef RELOAD_SCHED_CNT_EN
    ,
    output logic [7:0]                 reload_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] last_val_q, last_val_d;
    logic             underrun_q, underrun_d;

    logic match, empty, push, pop;

    always_comb begin
        match      = (count_i == term_i);
        empty      = (level_q == '0);
        in_ready_o = (level_q < FULL_LEVEL);
        // Reset gates the strobe so the counter never loads during a reset cycle.
        load_o     = !reset && (state_q == ARMED) && enable_i && match;
        load_val_o = empty ? last_val_q : mem_q[rd_ptr_q];
        push       = in_valid_i && in_ready_o;
        pop        = load_o && !empty;

        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
        last_val_d = pop ? mem_q[rd_ptr_q] : last_val_q;

        underrun_d = underrun_q;
        if (load_o && empty) begin
            underrun_d = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable_i) state_q <= ARMED;
                ARMED: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (load_o && oneshot_i) begin
                        state_q <= DONE;
                    end
                end
                DONE:    if (!enable_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            last_val_q <= DEFAULT_VAL;
            underrun_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            last_val_q <= last_val_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_val_i;
        end
    end

    assign level_o    = level_q;
    assign underrun_o = underrun_q;

`ifdef RELOAD_SCHED_CNT_EN
    logic [7:0] reload_cnt_q, reload_cnt_d;

    always_comb begin
        reload_cnt_d = reload_cnt_q;
        if (clr_underrun_i) begin
            reload_cnt_d = '0;
        end else if (load_o && (reload_cnt_q != '1)) begin
            reload_cnt_d = reload_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_cnt_q <= '0;
        end else begin
            reload_cnt_q <= reload_cnt_d;
        end
    end

    assign reload_cnt_o = reload_cnt_q;
`endif

endmodule

// File: tb/tb_reload_scheduler.sv
// Self-checking bench for reload_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_reload_scheduler;

    localparam int D = 4;
    localparam logic [3:0] DEF = 4'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, enable_i = 1'b0, oneshot_i = 1'b0;
    logic       in_valid_i = 1'b0, clr_underrun_i = 1'b0;
    logic [3:0] term_i = '0, count_i = '0, in_val_i = '0;
    logic       in_ready_o, load_o, underrun_o;
    logic [3:0] load_val_o;
    logic [2:0] level_o;
`ifdef RELOAD_SCHED_CNT_EN
    logic [7:0] reload_cnt_o;
`endif

    reload_scheduler #(.WIDTH(4), .DEPTH(D), .DEFAULT_VAL(DEF)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .oneshot_i(oneshot_i),
        .term_i(term_i), .count_i(count_i), .in_valid_i(in_valid_i), .in_val_i(in_val_i),
        .in_ready_o(in_ready_o), .clr_underrun_i(clr_underrun_i), .load_o(load_o),
        .load_val_o(load_val_o), .level_o(level_o), .underrun_o(underrun_o)
`ifdef RELOAD_SCHED_CNT_EN
        , .reload_cnt_o(reload_cnt_o)
`endif
    );

    int tests = 0, fails = 0;

    // Reference model: FIFO as a queue, mode as "running" / "spent" flags.
    int m_q[$];
    int m_last = DEF;
    bit m_under, m_running, m_spent, auto_cnt;
    int m_rc;

    logic [9:0] dut_vec;
    assign dut_vec = {load_o, load_val_o, level_o, in_ready_o, underrun_o};

    function automatic bit exp_load();
        return !reset && m_running && enable_i && (count_i == term_i);
    endfunction

    function automatic int exp_val();
        return (m_q.size() > 0) ? m_q[0] : m_last;
    endfunction

    function automatic logic [9:0] exp_vec();
        return {exp_load(), 4'(exp_val()), 3'(m_q.size()), (m_q.size() < D), m_under};
    endfunction

    // Advance one clock: update model from current inputs, then move the counter if auto-driven.
    task automatic step();
        bit         ld, was_empty, do_push;
        logic [3:0] nxt;
        ld        = exp_load();
        nxt       = ld ? 4'(exp_val()) : count_i + 4'd1;
        was_empty = (m_q.size() == 0);
        if (reset) begin
            m_q.delete();
            m_last = DEF; m_under = 0; m_running = 0; m_spent = 0; m_rc = 0;
        end else begin
            do_push = in_valid_i && (m_q.size() < D);
            if (ld && !was_empty) m_last = m_q.pop_front();
            if (ld && was_empty) m_under = 1;
            else if (clr_underrun_i) m_under = 0;
            if (do_push) m_q.push_back(int'(in_val_i));
            if (clr_underrun_i) m_rc = 0;
            else if (ld && m_rc < 255) m_rc++;
            if (m_spent) begin
                if (!enable_i) m_spent = 0;
            end else if (m_running) begin
                if (!enable_i) m_running = 0;
                else if (ld && oneshot_i) begin m_running = 0; m_spent = 1; end
            end else begin
                m_running = enable_i;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (auto_cnt) count_i = nxt;
    endtask

    task automatic do_reset();
        reset = 1; in_valid_i = 0; clr_underrun_i = 0; enable_i = 0; auto_cnt = 0;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; step(); step(); reset = 0; #1;
        tests++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec()); end
        tests++;
        if (load_val_o !== DEF) begin fails++; $display("FAIL reset_default got=%0d exp=%0d", load_val_o, DEF); end
`ifdef RELOAD_SCHED_CNT_EN
        tests++;
        if (reload_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", reload_cnt_o); end
`endif
    endtask

    task automatic test_continuous();
        int vals[$], lvls[$];
        int exp_v[3] = '{9, 3, 3};
        int exp_l[3] = '{2, 1, 0};
        enable_i = 1; oneshot_i = 0; term_i = 12; count_i = 0; auto_cnt = 1;
        in_valid_i = 1; in_val_i = 9; step();
        in_val_i = 3; step();
        in_valid_i = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL cont_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (load_o === 1'b1) begin vals.push_back(int'(load_val_o)); lvls.push_back(int'(level_o)); end
            step();
        end
        tests++;
        if (vals.size() < 3) begin
            fails++; $display("FAIL cont_reloads got=%0d exp>=3", vals.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (vals[i] != exp_v[i] || lvls[i] != exp_l[i]) begin
                    fails++; $display("FAIL cont_seq%0d got=%0d/%0d exp=%0d/%0d", i, vals[i], lvls[i], exp_v[i], exp_l[i]);
                end
            end
        end
        #1;
        tests++;
        if (underrun_o !== 1'b1) begin fails++; $display("FAIL cont_underrun got=%b exp=1", underrun_o); end
    endtask

    task automatic test_underrun();
        auto_cnt = 0; count_i = 0; clr_underrun_i = 1; #1;
        tests++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL under_clr_cycle got=%h exp=%h", dut_vec, exp_vec()); end
        step(); clr_underrun_i = 0; #1;
        tests++;
        if (underrun_o !== 1'b0) begin fails++; $display("FAIL under_cleared got=%b exp=0", underrun_o); end
        count_i = 12; clr_underrun_i = 1; #1;
        tests++;
        if (load_o !== 1'b1 || load_val_o !== 4'd3) begin fails++; $display("FAIL under_same_load got=%b/%0d exp=1/3", load_o, load_val_o); end
        step(); clr_underrun_i = 0; count_i = 0; #1;
        tests++;
        if (underrun_o !== 1'b1) begin fails++; $display("FAIL under_set_priority got=%b exp=1", underrun_o); end
    endtask

    task automatic test_full();
        int exp_order[4] = '{2, 3, 4, 5};
        do_reset();
        term_i = 12; count_i = 0; oneshot_i = 0;
        for (int i = 1; i <= 4; i++) begin
            in_valid_i = 1; in_val_i = 4'(i); #1;
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL full_push%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
            step();
        end
        in_val_i = 5; #1;
        tests++;
        if ({in_ready_o, level_o} !== {1'b0, 3'd4}) begin fails++; $display("FAIL full_backpressure got=%b/%0d exp=0/4", in_ready_o, level_o); end
        step();
        enable_i = 1; step();
        count_i = 12; #1;
        tests++;
        if ({load_o, load_val_o, in_ready_o} !== {1'b1, 4'd1, 1'b0}) begin
            fails++; $display("FAIL full_pop got=%b/%0d/%b exp=1/1/0", load_o, load_val_o, in_ready_o);
        end
        step(); count_i = 0; #1;
        tests++;
        if ({in_ready_o, level_o} !== {1'b1, 3'd3}) begin fails++; $display("FAIL full_after_pop got=%b/%0d exp=1/3", in_ready_o, level_o); end
        step(); in_valid_i = 0; #1;
        tests++;
        if (level_o !== 3'd4) begin fails++; $display("FAIL full_refill got=%0d exp=4", level_o); end
        for (int i = 0; i < 4; i++) begin
            count_i = 12; #1;
            tests++;
            if (load_val_o !== 4'(exp_order[i])) begin fails++; $display("FAIL full_order%0d got=%0d exp=%0d", i, load_val_o, exp_order[i]); end
            step();
        end
        count_i = 0;
    endtask

    task automatic test_oneshot();
        int vals[$];
        bit wrapped;
        logic [3:0] prev;
        do_reset();
        oneshot_i = 1; term_i = 15; count_i = 0;
        in_valid_i = 1; in_val_i = 7; step();
        in_val_i = 8; step();
        in_valid_i = 0; enable_i = 1; auto_cnt = 1;
        wrapped = 0; prev = count_i;
        for (int c = 0; c < 40; c++) begin
            #1;
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL oneshot_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (load_o === 1'b1) vals.push_back(int'(load_val_o));
            if (vals.size() > 0 && prev == 4'd15 && count_i == 4'd0) wrapped = 1;
            prev = count_i;
            step();
        end
        tests++;
        if (vals.size() != 1 || vals[0] != 7 || !wrapped) begin
            fails++; $display("FAIL oneshot_first got=%0d loads wrap=%b exp=1 load of 7 wrap=1", vals.size(), wrapped);
        end
        enable_i = 0; step();
        enable_i = 1;
        vals.delete();
        for (int c = 0; c < 40; c++) begin
            #1;
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL oneshot_rearm%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
            if (load_o === 1'b1) vals.push_back(int'(load_val_o));
            step();
        end
        tests++;
        if (vals.size() != 1 || vals[0] != 8) begin fails++; $display("FAIL oneshot_second got=%0d loads exp=1 load of 8", vals.size()); end
        auto_cnt = 0; oneshot_i = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        enable_i = 1; oneshot_i = 0; term_i = 5; count_i = 0; step();
        count_i = 5; in_valid_i = 1; in_val_i = 6; #1;
        tests++;
        if ({load_o, load_val_o} !== {1'b1, DEF}) begin fails++; $display("FAIL simul_nobypass got=%b/%0d exp=1/%0d", load_o, load_val_o, DEF); end
        step(); in_valid_i = 0; count_i = 0; #1;
        tests++;
        if ({underrun_o, level_o} !== {1'b1, 3'd1}) begin fails++; $display("FAIL simul_after got=%b/%0d exp=1/1", underrun_o, level_o); end
        count_i = 5; #1;
        tests++;
        if ({load_o, load_val_o} !== {1'b1, 4'd6}) begin fails++; $display("FAIL simul_next got=%b/%0d exp=1/6", load_o, load_val_o); end
        step(); enable_i = 0; #1;
        tests++;
        if (load_o !== 1'b0) begin fails++; $display("FAIL simul_disable got=%b exp=0", load_o); end
        step(); count_i = 0;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        enable_i = 1; oneshot_i = 0; term_i = 9; count_i = 0; step();
        count_i = 9; step();
        count_i = 0;
        for (int i = 0; i < 3; i++) begin in_valid_i = 1; in_val_i = 4'(10 + i); step(); end
        in_valid_i = 0; #1;
        tests++;
        if ({level_o, underrun_o} !== {3'd3, 1'b1}) begin fails++; $display("FAIL midrun_setup got=%0d/%b exp=3/1", level_o, underrun_o); end
        count_i = 9; reset = 1; #1;
        tests++;
        if (load_o !== 1'b0) begin fails++; $display("FAIL midrun_load got=%b exp=0", load_o); end
        step(); reset = 0; #1;
        tests++;
        if (dut_vec !== {1'b0, DEF, 3'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL midrun_after got=%h exp=%h", dut_vec, {1'b0, DEF, 3'd0, 1'b1, 1'b0});
        end
        step(); count_i = 0;
    endtask

    task automatic test_random();
        do_reset();
        term_i = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            reset          = ($urandom_range(0, 99) == 0);
            enable_i       = ($urandom_range(0, 9) != 0);
            oneshot_i      = ($urandom_range(0, 3) == 0);
            if (c % 50 == 0) term_i = 4'($urandom);
            count_i        = ($urandom_range(0, 2) == 0) ? term_i : 4'($urandom);
            in_valid_i     = $urandom_range(0, 1) == 1;
            in_val_i       = 4'($urandom);
            clr_underrun_i = ($urandom_range(0, 9) == 0);
            #1;
            tests++;
            if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
`ifdef RELOAD_SCHED_CNT_EN
            tests++;
            if (reload_cnt_o !== 8'(m_rc)) begin fails++; $display("FAIL random_cnt%0d got=%0d exp=%0d", c, reload_cnt_o, m_rc); end
`endif
            step();
        end
        reset = 0; in_valid_i = 0; clr_underrun_i = 0;
    endtask

`ifdef RELOAD_SCHED_CNT_EN
    task automatic test_cnt_saturate();
        do_reset();
        enable_i = 1; oneshot_i = 0; term_i = 3; count_i = 0; step();
        count_i = 3;
        for (int i = 0; i < 260; i++) step();
        #1;
        tests++;
        if (reload_cnt_o !== 8'd255) begin fails++; $display("FAIL cnt_saturate got=%0d exp=255", reload_cnt_o); end
        clr_underrun_i = 1; step(); clr_underrun_i = 0; #1;
        tests++;
        if (reload_cnt_o !== 8'd0) begin fails++; $display("FAIL cnt_clear got=%0d exp=0", reload_cnt_o); end
        count_i = 0; enable_i = 0; step();
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_underrun();
        test_full();
        test_oneshot();
        test_simultaneous();
        test_reset_midrun();
        test_random();
`ifdef RELOAD_SCHED_CNT_EN
        test_cnt_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
